sim_run_ctrl: RTL and testbench

SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

---
 rtl/sim_run_ctrl.sv | 132 +++++++++++++
 tb/tb_sim_run_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// Run controller for a processor under simulation: holds it in reset, lets it run
// until a halt instruction retires or a cycle limit expires, then drains and reports.
module sim_run_ctrl #(
    parameter int                  OPCODE_W       = 6,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE    = 6'h11,
    parameter int unsigned         RESET_CYCLES   = 2,
    parameter int unsigned         DRAIN_CYCLES   = 4,
    parameter int unsigned         TIMEOUT_CYCLES = 100000,
    parameter int                  CNT_W          = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                wb_valid,
    input  logic [OPCODE_W-1:0] wb_opcode,
    output logic                cpu_reset,
    output logic                done,
    output logic                halted,
    output logic                timed_out,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    retired_count,
    output logic [2:0]          state
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RESET_HOLD = 3'd1;
    localparam logic [2:0] S_RUN        = 3'd2;
    localparam logic [2:0] S_DRAIN      = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    localparam logic [31:0] HOLD_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);
    localparam logic [63:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 64'd0 : 64'(TIMEOUT_CYCLES) - 64'd1;

    logic [2:0]       state_reg, state_next;
    logic [31:0]      phase_reg, phase_next;
    logic [CNT_W-1:0] cycle_reg, cycle_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic             halted_reg, halted_next;
    logic             timed_reg, timed_next;
    logic             done_reg, done_next;
    logic             cpu_reset_reg, cpu_reset_next;

    logic halt_hit;
    logic timeout_hit;
    logic start_run;

    assign halt_hit    = wb_valid && (wb_opcode == HALT_OPCODE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (64'(cycle_reg) == TIMEOUT_LAST);
    assign start_run   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            phase_reg     <= 32'd0;
            cycle_reg     <= '0;
            retired_reg   <= '0;
            halted_reg    <= 1'b0;
            timed_reg     <= 1'b0;
            done_reg      <= 1'b0;
            cpu_reset_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            cycle_reg     <= cycle_next;
            retired_reg   <= retired_next;
            halted_reg    <= halted_next;
            timed_reg     <= timed_next;
            done_reg      <= done_next;
            cpu_reset_reg <= cpu_reset_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) state_next = S_RESET_HOLD;
            end
            S_RESET_HOLD: begin
                if (phase_reg == HOLD_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                // a halt retiring on the timeout cycle still counts as a halt
                if (halt_hit)         state_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_DRAIN: begin
                if (phase_reg == DRAIN_LAST) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        phase_next   = phase_reg;
        cycle_next   = cycle_reg;
        retired_next = retired_reg;
        halted_next  = halted_reg;
        timed_next   = timed_reg;

        if (state_next != state_reg) begin
            phase_next = 32'd0;
        end else if ((state_reg == S_RESET_HOLD) || (state_reg == S_DRAIN)) begin
            phase_next = phase_reg + 32'd1;
        end

        if (start_run) begin
            cycle_next   = '0;
            retired_next = '0;
            halted_next  = 1'b0;
            timed_next   = 1'b0;
        end else if (state_reg == S_RUN) begin
            if (cycle_reg != {CNT_W{1'b1}}) cycle_next = cycle_reg + CNT_W'(1);
            if (wb_valid && (retired_reg != {CNT_W{1'b1}})) retired_next = retired_reg + CNT_W'(1);
            halted_next = halt_hit;
            timed_next  = !halt_hit && timeout_hit;
        end

        done_next      = (state_next == S_DONE);
        cpu_reset_next = (state_next == S_IDLE) || (state_next == S_RESET_HOLD);
    end

    assign state         = state_reg;
    assign cpu_reset     = cpu_reset_reg;
    assign done          = done_reg;
    assign halted        = halted_reg;
    assign timed_out     = timed_reg;
    assign cycle_count   = cycle_reg;
    assign retired_count = retired_reg;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Drives four differently-parameterised controllers with one shared random stream and
// predicts each one's timeline from the run rules (halt index, timeout, drain length).
module tb_sim_run_ctrl;

    localparam int NDUT = 4;
    localparam int K    = 56;

    // per-instance parameters, instance d in bits [d*32 +: 32]
    localparam logic [127:0] RS_P = {32'd3, 32'd2, 32'd2, 32'd2};
    localparam logic [127:0] DR_P = {32'd3, 32'd0, 32'd4, 32'd4};
    localparam logic [127:0] TO_P = {32'd0, 32'd100000, 32'd8, 32'd100000};
    localparam logic [127:0] CW_P = {32'd4, 32'd32, 32'd32, 32'd32};

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic wb_valid;
    logic [5:0] wb_opcode;

    logic [NDUT-1:0]    cr_f, done_f, halted_f, timed_f;
    logic [NDUT*3-1:0]  st_f;
    logic [NDUT*32-1:0] cyc_f, ret_f;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int CW = int'(CW_P[gi*32 +: 32]);
        logic [CW-1:0] cc, rc;
        sim_run_ctrl #(
            .OPCODE_W      (6),
            .HALT_OPCODE   (6'h11),
            .RESET_CYCLES  (RS_P[gi*32 +: 32]),
            .DRAIN_CYCLES  (DR_P[gi*32 +: 32]),
            .TIMEOUT_CYCLES(TO_P[gi*32 +: 32]),
            .CNT_W         (CW)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start),
            .wb_valid     (wb_valid),
            .wb_opcode    (wb_opcode),
            .cpu_reset    (cr_f[gi]),
            .done         (done_f[gi]),
            .halted       (halted_f[gi]),
            .timed_out    (timed_f[gi]),
            .cycle_count  (cc),
            .retired_count(rc),
            .state        (st_f[gi*3 +: 3])
        );
        assign cyc_f[gi*32 +: 32] = 32'(cc);
        assign ret_f[gi*32 +: 32] = 32'(rc);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cur_dut  = 0;
    int cur_k    = 0;

    bit         sv [0:63];
    logic [5:0] so [0:63];
    int         end_e    [NDUT];
    bit         halt_e   [NDUT];
    int         busy_min;
    int         abort_k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d k=%0d: got %0h expected %0h", tag, cur_dut, cur_k, got, exp);
        end
    endtask

    function automatic int gp(input logic [127:0] v, input int d);
        return int'(v[d*32 +: 32]);
    endfunction

    function automatic int sat(input int x, input int cw);
        int m;
        m = (cw >= 31) ? 32'h7fffffff : ((1 << cw) - 1);
        return (x > m) ? m : x;
    endfunction

    // instructions retired in the first n RUN cycles of a controller with hold length r
    function automatic int vcount(input int r, input int n);
        int c = 0;
        for (int j = 1; j <= n; j++) if (r + j <= 63 && sv[r + j]) c++;
        return c;
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        op = 6'($urandom_range(0, 63));
        if (op == 6'h11) op = 6'h12;
        return op;
    endfunction

    task automatic build_stream(input int run);
        for (int k = 0; k < 64; k++) begin
            case (run)
                0, 1, 2, 4: begin sv[k] = 1'b1; so[k] = rand_op(); end
                3:          begin sv[k] = 1'b0; so[k] = rand_op(); end
                default: begin
                    sv[k] = ($urandom_range(0, 3) != 0);
                    so[k] = (sv[k] && $urandom_range(0, 15) == 0) ? 6'h11 : rand_op();
                end
            endcase
        end
        case (run)
            0: so[12] = 6'h11;
            1: so[10] = 6'h11;
            2: so[3]  = 6'h11;
            4: so[40] = 6'h11;
            default: ;
        endcase
        sv[50] = 1'b1;
        so[50] = 6'h11;
        abort_k = 0;
        if (run == 5) abort_k = 5;
        else if (run > 5 && $urandom_range(0, 3) == 0) abort_k = $urandom_range(1, K);
    endtask

    task automatic compute_model();
        int r, t, h;
        busy_min = K + 1;
        for (int d = 0; d < NDUT; d++) begin
            r = gp(RS_P, d);
            t = gp(TO_P, d);
            h = 0;
            for (int j = 1; r + j <= K; j++) begin
                if (sv[r + j] && so[r + j] == 6'h11) begin h = j; break; end
            end
            if (h != 0 && (t == 0 || h <= t)) begin
                end_e[d]  = h;
                halt_e[d] = 1'b1;
            end else begin
                end_e[d]  = t;
                halt_e[d] = 1'b0;
            end
            if (r + end_e[d] + (halt_e[d] ? gp(DR_P, d) : 0) < busy_min)
                busy_min = r + end_e[d] + (halt_e[d] ? gp(DR_P, d) : 0);
        end
    endtask

    task automatic check_cycle(input int k);
        int r, dr, cw, j;
        int e_st, e_cr, e_cyc, e_ret, e_h, e_t;
        for (int d = 0; d < NDUT; d++) begin
            cur_dut = d;
            r  = gp(RS_P, d);
            dr = gp(DR_P, d);
            cw = gp(CW_P, d);
            e_h = 0; e_t = 0;
            if (k <= r) begin
                e_st = 1; e_cr = 1; e_cyc = 0; e_ret = 0;
            end else if (k <= r + end_e[d]) begin
                j = k - r;
                e_st = 2; e_cr = 0;
                e_cyc = sat(j - 1, cw);
                e_ret = sat(vcount(r, j - 1), cw);
            end else begin
                e_cr  = 0;
                e_cyc = sat(end_e[d], cw);
                e_ret = sat(vcount(r, end_e[d]), cw);
                e_h   = halt_e[d] ? 1 : 0;
                e_t   = halt_e[d] ? 0 : 1;
                e_st  = (halt_e[d] && k <= r + end_e[d] + dr) ? 3 : 4;
            end
            check("state",     32'(st_f[d*3 +: 3]), 32'(e_st));
            check("cpu_reset", 32'(cr_f[d]),        32'(e_cr));
            check("done",      32'(done_f[d]),      32'(e_st == 4));
            check("halted",    32'(halted_f[d]),    32'(e_h));
            check("timed_out", 32'(timed_f[d]),     32'(e_t));
            check("cycles",    cyc_f[d*32 +: 32],   32'(e_cyc));
            check("retired",   ret_f[d*32 +: 32],   32'(e_ret));
        end
    endtask

    task automatic check_idle();
        for (int d = 0; d < NDUT; d++) begin
            cur_dut = d;
            check("idle_state",   32'(st_f[d*3 +: 3]), 32'd0);
            check("idle_cpu_rst", 32'(cr_f[d]),        32'd1);
            check("idle_flags",   32'({done_f[d], halted_f[d], timed_f[d]}), 32'd0);
            check("idle_cycles",  cyc_f[d*32 +: 32],   32'd0);
            check("idle_retired", ret_f[d*32 +: 32],   32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; wb_valid = 1'b1; wb_opcode = 6'h11;
        repeat (2) @(posedge clk);
        #1;
        cur_k = 0;
        check_idle();
        reset = 1'b0; start = 1'b0; wb_valid = 1'b0;
        @(posedge clk);
        #1;
        check_idle();

        for (int run = 0; run < 20; run++) begin
            build_stream(run);
            compute_model();
            start = 1'b1;
            wb_valid = sv[0];
            wb_opcode = so[0];
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int k = 1; k <= K; k++) begin
                cur_k = k;
                check_cycle(k);
                if (k == abort_k) begin
                    reset = 1'b1; start = 1'b1; wb_valid = 1'b1; wb_opcode = 6'h11;
                    @(posedge clk);
                    #1;
                    reset = 1'b0; start = 1'b0; wb_valid = 1'b0;
                    check_idle();
                    @(posedge clk);
                    #1;
                    check_idle();
                    break;
                end
                if (k == K) break;
                wb_valid  = sv[k];
                wb_opcode = so[k];
                start     = (k <= busy_min) && ($urandom_range(0, 7) == 0);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            $display("run %0d: abort_k=%0d end=%0d/%0d/%0d/%0d halt=%0d%0d%0d%0d errors so far %0d",
                     run, abort_k, end_e[0], end_e[1], end_e[2], end_e[3],
                     halt_e[0], halt_e[1], halt_e[2], halt_e[3], n_errors);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
